// File: rtl/regfile_wb_buffer.sv
// Write-back buffer in front of the register file: queues accepted writes,
// retires one per cycle as a one-hot enable, and forwards pending values to two read ports.
module regfile_wb_fwd #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data_i,
  input  logic [DEPTH-1:0]             ent_vld_i,
  input  logic                         out_vld_i,
  input  logic [ADDR_W-1:0]            out_addr_i,
  input  logic [DATA_W-1:0]            out_data_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);
  // Entries arrive ordered oldest-first, so later matches override earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (rd_addr_i != '0) begin
      if (out_vld_i && out_addr_i == rd_addr_i) begin
        hit_o  = 1'b1;
        data_o = out_data_i;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (ent_vld_i[k] && ent_addr_i[k] == rd_addr_i) begin
          hit_o  = 1'b1;
          data_o = ent_data_i[k];
        end
      end
    end
  end
endmodule

module regfile_wb_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     hold,
  output logic [(1<<ADDR_W)-1:0]   reg_en,
  output logic [DATA_W-1:0]        reg_wdata,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  output logic                     rd_hit_a,
  output logic                     rd_hit_b,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;
  localparam int NRD   = 2;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [NREG-1:0]              reg_en_q, reg_en_d;
  logic [DATA_W-1:0]            reg_wdata_q;
  logic                         out_vld_q;
  logic [ADDR_W-1:0]            out_addr_q;
  logic                         push, pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wb_ready = !full;
  assign count    = count_q;
  assign reg_en   = reg_en_q;
  assign reg_wdata = reg_wdata_q;

  // r0 writes complete the handshake but never occupy a slot.
  assign push = wb_valid && !full && (wb_addr != '0);
  assign pop  = !empty && !hold;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    reg_en_d = '0;
    if (pop) reg_en_d = NREG'(1) << addr_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      data_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      reg_en_q    <= '0;
      reg_wdata_q <= '0;
      out_vld_q   <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q] <= wb_addr;
        data_q[wr_ptr_q] <= wb_data;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        reg_wdata_q <= data_q[rd_ptr_q];
        out_addr_q  <= addr_q[rd_ptr_q];
      end
      out_vld_q <= pop;
      reg_en_q  <= reg_en_d;
      count_q   <= count_d;
    end
  end

  // Queue contents rotated into age order (index 0 = head) for the forwarders.
  logic [DEPTH-1:0][ADDR_W-1:0] ord_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;
  logic [DEPTH-1:0]             ord_vld;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      logic [PTR_W-1:0] idx;
      idx         = rd_ptr_q + PTR_W'(k);
      ord_addr[k] = addr_q[idx];
      ord_data[k] = data_q[idx];
      ord_vld[k]  = (CNT_W'(k) < count_q);
    end
  end

  logic [NRD-1:0][ADDR_W-1:0] rd_addr;
  logic [NRD-1:0]             rd_hit;
  logic [NRD-1:0][DATA_W-1:0] rd_data;

  assign rd_addr   = {rd_addr_b, rd_addr_a};
  assign rd_hit_a  = rd_hit[0];
  assign rd_hit_b  = rd_hit[1];
  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];

  for (genvar p = 0; p < NRD; p++) begin : g_fwd
    regfile_wb_fwd #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd (
      .ent_addr_i (ord_addr),
      .ent_data_i (ord_data),
      .ent_vld_i  (ord_vld),
      .out_vld_i  (out_vld_q),
      .out_addr_i (out_addr_q),
      .out_data_i (reg_wdata_q),
      .rd_addr_i  (rd_addr[p]),
      .hit_o      (rd_hit[p]),
      .data_o     (rd_data[p])
    );
  end
endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed bench for regfile_wb_buffer: push/drain, hold/full, forwarding, r0, wrap, async reset.
module tb_regfile_wb_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_ready, hold;
  logic [4:0]  wb_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wb_data, reg_en, reg_wdata, rd_data_a, rd_data_b;
  logic        rd_hit_a, rd_hit_b, full, empty;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_buffer dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .hold(hold), .reg_en(reg_en),
    .reg_wdata(reg_wdata), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_hit_a(rd_hit_a), .rd_hit_b(rd_hit_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    int p;
    rst_n = 1'b0; hold = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    drive(1'b0, '0, '0);
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", wb_ready, 1);
    chk("rst_en", reg_en, 0);
    chk("rst_wdata", reg_wdata, 0);
    rst_n = 1'b1;

    // single write: latency and one-cycle enable
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    rd_addr_a = 5'd5;
    tick();
    drive(1'b0, '0, '0);
    chk("t1_count1", count, 1);
    chk("t1_en0", reg_en, 0);
    chk("t1_ready", wb_ready, 1);
    chk("t1_fwd_fifo", {rd_hit_a, rd_data_a}, {1'b1, 32'hDEADBEEF});
    tick();
    chk("t1_en", reg_en, 32'h0000_0020);
    chk("t1_wdata", reg_wdata, 32'hDEADBEEF);
    chk("t1_count0", count, 0);
    chk("t1_fwd_out", {rd_hit_a, rd_data_a}, {1'b1, 32'hDEADBEEF});
    tick();
    chk("t1_en_off", reg_en, 0);
    chk("t1_wdata_hold", reg_wdata, 32'hDEADBEEF);
    chk("t1_fwd_gone", {rd_hit_a, rd_data_a}, {1'b0, 32'h0});

    // hold and fill, fifth write ignored, drain in order
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'(i * 'h11));
      tick();
    end
    chk("t2_full", full, 1);
    chk("t2_ready", wb_ready, 0);
    chk("t2_count", count, 4);
    drive(1'b1, 5'd9, 32'h99);
    tick();
    chk("t2_ignored", count, 4);
    chk("t2_held_en", reg_en, 0);
    drive(1'b0, '0, '0);
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_drain_en", reg_en, 64'(32'd1 << i));
      chk("t2_drain_data", reg_wdata, 32'(i * 'h11));
    end
    tick();
    chk("t2_no_fifth", reg_en, 0);
    chk("t2_empty", empty, 1);

    // repeated writes to one address: youngest forwarded, in-order retire
    hold = 1'b1;
    rd_addr_a = 5'd7;
    drive(1'b1, 5'd7, 32'hA); tick();
    drive(1'b1, 5'd7, 32'hB); tick();
    drive(1'b0, '0, '0);
    chk("t3_fwd_young", {rd_hit_a, rd_data_a}, {1'b1, 32'hB});
    hold = 1'b0;
    tick();
    chk("t3_ret_a", {reg_en, reg_wdata}, {32'h80, 32'hA});
    chk("t3_fwd_b1", {rd_hit_a, rd_data_a}, {1'b1, 32'hB});
    tick();
    chk("t3_ret_b", {reg_en, reg_wdata}, {32'h80, 32'hB});
    chk("t3_fwd_b2", {rd_hit_a, rd_data_a}, {1'b1, 32'hB});
    tick();
    chk("t3_hit_drop", {rd_hit_a, rd_data_a}, {1'b0, 32'h0});
    chk("t3_en_off", reg_en, 0);

    // r0 write discarded
    rd_addr_b = 5'd0;
    drive(1'b1, 5'd0, 32'hFFFFFFFF);
    chk("t4_ready", wb_ready, 1);
    tick();
    drive(1'b0, '0, '0);
    chk("t4_count", count, 0);
    chk("t4_empty", empty, 1);
    tick();
    chk("t4_no_en", reg_en, 0);
    chk("t4_rd0", {rd_hit_b, rd_data_b}, {1'b0, 32'h0});

    // full FIFO released with wb_valid held: ten writes through four slots
    hold = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 5'(10 + j), 32'hC000 + 32'(j));
      tick();
    end
    chk("t5_full", full, 1);
    p = 4;
    drive(1'b1, 5'(10 + p), 32'hC000 + 32'(p));
    hold = 1'b0;
    tick();
    chk("t5_ret0", {reg_en, reg_wdata}, {32'd1 << 10, 32'hC000});
    chk("t5_cnt0", count, 3);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk("t5_ret", {reg_en, reg_wdata}, {32'd1 << (10 + k), 32'hC000 + 32'(k)});
      chk("t5_cnt", count, (k <= 6) ? 3 : 9 - k);
      p++;
      if (p < 10) drive(1'b1, 5'(10 + p), 32'hC000 + 32'(p));
      else        drive(1'b0, '0, '0);
    end
    tick();
    chk("t5_idle", reg_en, 0);

    // asynchronous reset with three queued and one in flight
    hold = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 5'(20 + j), 32'hE000 + 32'(j));
      tick();
    end
    drive(1'b0, '0, '0);
    hold = 1'b0;
    tick();
    chk("t6_pre_cnt", count, 3);
    chk("t6_pre_en", reg_en, 32'd1 << 20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cnt", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_en", reg_en, 0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no_retire", reg_en, 0);
    end
    chk("t6_cnt_after", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_buffer.md
# regfile_wb_buffer

Write-back buffer that sits directly upstream of the register file's 32 enable-gated 32-bit storage registers. It accepts register writes from the pipeline's write-back stage through a valid/ready handshake and queues them in a small FIFO. It retires one write per cycle as a one-hot register enable plus write data, and forwards queued or in-flight values to two read ports so reads never return stale data.

## Interface
- DATA_W, 32, width of a register value
- ADDR_W, 5, register address width (2^ADDR_W = 32 registers)
- DEPTH, 4, FIFO entries (power of two, ≥ 2)

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wb_valid  in  1  write-back request valid
- wb_ready  out  1  buffer can accept; equals !full
- wb_addr  in  ADDR_W  destination register
- wb_data  in  DATA_W  write value
- hold  in  1  pauses draining (pipeline/regfile busy)
- reg_en  out  2^ADDR_W  one-hot per-register write enable, registered
- reg_wdata  out  DATA_W  data shared by all registers, registered
- rd_addr_a, rd_addr_b  in  ADDR_W  read port addresses
- rd_hit_a, rd_hit_b  out  1  forwarded value valid; use rd_data instead of register contents
- rd_data_a, rd_data_b  out  DATA_W  forwarded value (0 when no hit)
- count  out  log2(DEPTH)+1  entries currently queued
- full, empty  out  1  FIFO status

## Operation
- Reset while rst_n=0: rd/wr pointers=0, count=0, empty=1, full=0, wb_ready=1, reg_en=0, reg_wdata=0, internal in-flight valid=0. Asserting rst_n mid-operation discards all queued and in-flight writes immediately.
- Push: a write is accepted on a rising edge when wb_valid && wb_ready. wb_addr=0 is accepted but discarded, because r0 is hardwired zero. It is never enqueued and count does not change.
- Drain: on each edge where the FIFO is non-empty and hold=0, the head entry pops. The output stage loads reg_en = one-hot(head addr) and reg_wdata = head data.
- When no pop occurs, reg_en=0 for the following cycle. reg_wdata holds its last value.
- reg_en is never more than one-hot and is never asserted for bit 0.
- Simultaneous push and pop: both occur and count is unchanged. A push into an empty FIFO cannot pop on the same edge; the entry drains on the next edge at the earliest.
- Full: wb_ready=0 and wb_valid is ignored, even if a pop happens on the same edge. The freed slot is visible the next cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Forwarding is combinational on rd_addr_x. Sources, in priority order:
  1. The youngest FIFO entry with a matching addr.
  2. Otherwise, the in-flight output stage (reg_en asserted for that address this cycle).
  3. Otherwise rd_hit=0 and rd_data=0.
- rd_addr_x=0 always gives hit=0 and data=0. A same-cycle wb_valid/wb_data is not forwarded; the write-back stage bypasses its own value.
- Repeated writes to one address are all retired in order. The register ends with the last value.

## Timing
- Accept at edge N → earliest pop at edge N+1 → reg_en high during cycle N+1..N+2 → register captures at edge N+2. Write latency is 2 cycles when empty and unheld.
- Forwarding covers the entry from edge N (FIFO) through edge N+2 (output stage). After the capture, the register itself holds the value.
- Throughput is one retire per cycle. Sustained one-per-cycle pushes never fill the FIFO when hold=0.
- hold=1 at edge K: no pop, reg_en=0 in the cycle after K, FIFO contents unchanged.

## Test plan
- Reset, then push (addr 5, 0xDEADBEEF) with hold=0:
  - wb_ready=1 throughout.
  - reg_en=0x00000020 and reg_wdata=0xDEADBEEF in exactly the one cycle starting at the second edge after accept.
  - count goes 1→0.
- hold=1, push addrs 1,2,3,4 with data 0x11..0x44:
  - After the 4th accept: full=1, wb_ready=0, count=4.
  - A 5th wb_valid is ignored.
  - Release hold: reg_en = bit1, bit2, bit3, bit4 on consecutive cycles with matching data.
- hold=1, push (7, 0xA), then (7, 0xB):
  - rd_addr_a=7 gives rd_hit_a=1, rd_data_a=0xB.
  - After draining, 0xA retires then 0xB.
  - rd_hit_a drops to 0 the cycle after the 0xB enable.
- Push (0, 0xFFFFFFFF):
  - Accepted, count stays 0, reg_en never asserts.
  - rd_addr_b=0 gives rd_hit_b=0, rd_data_b=0.
- Full FIFO with hold=0 and wb_valid held high:
  - Pushes resume one cycle after the first pop; count then stays constant.
  - Pointers wrap past DEPTH with correct data order over 10 writes.
- Drop rst_n asynchronously (between edges) while count=3:
  - count=0, empty=1, reg_en=0 immediately without a clock edge.
  - No queued write retires after release.
